pipe_fetch_queue: RTL and testbench

Parametrised successor to the single-entry fetch stage. It runs ahead of decode, keeping up to QUEUE_DEPTH prefetched instructions with their PCs. Sits between the core pipe controller and the instruction memory port. Adds redirect/flush, a per-entry PC, an occupancy count and a sticky misalignment halt.

---
 rtl/pipe_fetch_queue_pkg.sv | 19 +
 rtl/pipe_fetch_queue_if.sv | 15 +
 rtl/pipe_fetch_queue_fifo.sv | 57 +++++
 rtl/pipe_fetch_queue.sv | 133 +++++++++++++
 tb/tb_pipe_fetch_queue.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_fetch_queue_pkg.sv
// Shared types and helpers for the prefetching fetch queue.
package pipe_fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FETCH      = 2'd1,
    ST_MISALIGNED = 2'd2
  } fetch_state_e;

  // Byte distance between consecutive instruction words.
  function automatic int unsigned pc_step(input int unsigned instr_width);
    return instr_width / 8;
  endfunction

  function automatic int unsigned align_mask(input int unsigned instr_width);
    return pc_step(instr_width) - 1;
  endfunction

endpackage

// File: rtl/pipe_fetch_queue_if.sv
// Instruction memory port between the fetch queue and instruction memory.
interface pipe_fetch_queue_if #(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned INSTRUCTION_WIDTH = 32
) ();
  logic [ADDRESS_WIDTH-1:0]     fetchAddress;
  logic                         fetchEnable;
  logic                         fetchBusy;
  logic [INSTRUCTION_WIDTH-1:0] fetchData;

  modport master (output fetchAddress, output fetchEnable,
                  input  fetchBusy,    input  fetchData);
  modport slave  (input  fetchAddress, input  fetchEnable,
                  output fetchBusy,    output fetchData);
endinterface

// File: rtl/pipe_fetch_queue_fifo.sv
// Circular-buffer FIFO holding {instruction, pc} entries; flush beats push.
module pipe_fetch_queue_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      wr_en = push;
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    if (wr_en) mem_q[tail_q] <= wdata;
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/pipe_fetch_queue.sv
// Prefetching fetch stage: runs ahead of decode, buffering up to QUEUE_DEPTH
// {instruction, pc} pairs, with redirect/flush and a sticky misalignment halt.
module pipe_fetch_queue
  import pipe_fetch_queue_pkg::*;
#(
  parameter int unsigned                 ADDRESS_WIDTH         = 32,
  parameter int unsigned                 INSTRUCTION_WIDTH     = 32,
  parameter int unsigned                 QUEUE_DEPTH           = 4,
  parameter logic [ADDRESS_WIDTH-1:0]     PROGRAM_COUNTER_RESET = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0] INVALID_INSTRUCTION   = '1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pipeStartup,
  input  logic                           stepPipe,
  input  logic                           pipeStall,
  output logic                           currentPipeStall,
  output logic                           active,
  output logic [INSTRUCTION_WIDTH-1:0]   lastInstruction,
  output logic [ADDRESS_WIDTH-1:0]       lastProgramCounter,
  output logic                           lastValid,
  input  logic                           redirectValid,
  input  logic [ADDRESS_WIDTH-1:0]       redirectAddress,
  output logic                           addressMisaligned,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy,
  pipe_fetch_queue_if.master             mem
);
  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned ENTRY_W = INSTRUCTION_WIDTH + ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(pc_step(INSTRUCTION_WIDTH));
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(align_mask(INSTRUCTION_WIDTH));

  fetch_state_e                 state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic [INSTRUCTION_WIDTH-1:0] last_instr_q, last_instr_d;
  logic [ADDRESS_WIDTH-1:0]     last_pc_q, last_pc_d;
  logic                         last_valid_q, last_valid_d;
  logic                         cur_stall_q, cur_stall_d;
  logic                         misaligned_q, misaligned_d;

  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] head_entry;
  logic               pop_req, pop, push, accept, fetch_en, target_misaligned;

  // The pop term in fetch_en is not gated by redirect: a full queue still
  // issues a request alongside a redirect, and the flush discards the word.
  always_comb begin
    pop_req           = stepPipe && !pipeStall && (fifo_count != '0);
    fetch_en          = (state_q == ST_FETCH) &&
                        ((fifo_count < CNT_W'(QUEUE_DEPTH)) || pop_req);
    accept            = fetch_en && !mem.fetchBusy;
    push              = accept && !redirectValid;
    pop               = pop_req && !redirectValid;
    target_misaligned = (redirectAddress & ALIGN_MASK) != '0;
  end

  pipe_fetch_queue_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirectValid),
    .push  (push),
    .pop   (pop),
    .wdata ({mem.fetchData, fetch_pc_q}),
    .rdata (head_entry),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;
    last_valid_d = last_valid_q;
    cur_stall_d  = cur_stall_q;
    misaligned_d = misaligned_q;
    if (redirectValid) begin
      fetch_pc_d   = redirectAddress;
      misaligned_d = target_misaligned;
      state_d      = target_misaligned ? ST_MISALIGNED : ST_FETCH;
      if (stepPipe) begin
        last_instr_d = INVALID_INSTRUCTION;
        last_valid_d = 1'b0;
        cur_stall_d  = 1'b1;
      end
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (state_q == ST_IDLE && pipeStartup) state_d = ST_FETCH;
      if (pop) begin
        {last_instr_d, last_pc_d} = head_entry;
        last_valid_d = 1'b1;
        cur_stall_d  = 1'b0;
      end else if (stepPipe) begin
        last_instr_d = INVALID_INSTRUCTION;
        last_valid_d = 1'b0;
        cur_stall_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= PROGRAM_COUNTER_RESET;
      last_instr_q <= INVALID_INSTRUCTION;
      last_pc_q    <= PROGRAM_COUNTER_RESET;
      last_valid_q <= 1'b0;
      cur_stall_q  <= 1'b1;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
      last_valid_q <= last_valid_d;
      cur_stall_q  <= cur_stall_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign mem.fetchEnable   = fetch_en;
  assign mem.fetchAddress  = fetch_pc_q;
  assign active            = (state_q == ST_FETCH) && !pipeStall;
  assign lastInstruction   = last_instr_q;
  assign lastProgramCounter = last_pc_q;
  assign lastValid         = last_valid_q;
  assign currentPipeStall  = cur_stall_q;
  assign addressMisaligned = misaligned_q;
  assign occupancy         = fifo_count;

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Self-checking bench for pipe_fetch_queue against a queue-based reference model.
module tb_pipe_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, pipeStartup, stepPipe, pipeStall, redirectValid, busy_r;
  logic [31:0] redirectAddress;
  logic        currentPipeStall, active, lastValid, addressMisaligned;
  logic [31:0] lastInstruction, lastProgramCounter;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  pipe_fetch_queue_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  assign bus.fetchBusy = busy_r;
  assign bus.fetchData = mem_word(bus.fetchAddress);

  pipe_fetch_queue dut (
    .clk                (clk),
    .rst                (rst),
    .pipeStartup        (pipeStartup),
    .stepPipe           (stepPipe),
    .pipeStall          (pipeStall),
    .currentPipeStall   (currentPipeStall),
    .active             (active),
    .lastInstruction    (lastInstruction),
    .lastProgramCounter (lastProgramCounter),
    .lastValid          (lastValid),
    .redirectValid      (redirectValid),
    .redirectAddress    (redirectAddress),
    .addressMisaligned  (addressMisaligned),
    .occupancy          (occupancy),
    .mem                (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0=idle 1=fetch 2=misaligned; queue holds {instr, pc}.
  int          m_state;
  logic [31:0] m_pc, m_last_i, m_last_pc;
  logic        m_last_v, m_stall, m_mis;
  logic [63:0] m_q [$];

  // Combinational outputs seen just before the edge, and the model's view.
  logic        obs_fe, obs_act, exp_fe, exp_act;
  logic [31:0] obs_fa, exp_fa;

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_pc = 32'h0; m_last_i = 32'hFFFF_FFFF; m_last_pc = 32'h0;
    m_last_v = 1'b0; m_stall = 1'b1; m_mis = 1'b0;
  endtask

  task automatic bubble();
    m_last_i = 32'hFFFF_FFFF; m_last_v = 1'b0; m_stall = 1'b1;
  endtask

  task automatic apply(input logic r, input logic su, input logic st, input logic ps,
                       input logic rv, input logic [31:0] ra, input logic bz);
    logic        pop_req;
    logic [63:0] e;
    @(negedge clk);
    rst = r; pipeStartup = su; stepPipe = st; pipeStall = ps;
    redirectValid = rv; redirectAddress = ra; busy_r = bz;
    #1;
    pop_req = st && !ps && (m_q.size() > 0);
    exp_fe  = (m_state == 1) && ((m_q.size() < 4) || pop_req);
    exp_fa  = m_pc;
    exp_act = (m_state == 1) && !ps;
    obs_fe  = bus.fetchEnable;
    obs_fa  = bus.fetchAddress;
    obs_act = active;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (rv) begin
      m_q.delete();
      m_pc = ra;
      if (st) bubble();
      m_mis = (ra[1:0] != 2'b00);
      m_state = m_mis ? 2 : 1;
    end else begin
      if (pop_req) begin
        e = m_q.pop_front();
        m_last_i = e[63:32]; m_last_pc = e[31:0]; m_last_v = 1'b1; m_stall = 1'b0;
      end else if (st) begin
        bubble();
      end
      if (exp_fe && !bz) begin
        m_q.push_back({mem_word(m_pc), m_pc});
        m_pc = m_pc + 32'd4;
      end
      if (m_state == 0 && su) m_state = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (lastInstruction !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_instr got %h exp ffffffff", lastInstruction); end
    checks++; if ({lastValid, currentPipeStall, addressMisaligned} !== 3'b010) begin errors++; $display("FAIL reset_flags got %b exp 010", {lastValid, currentPipeStall, addressMisaligned}); end
    checks++; if (lastProgramCounter !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", lastProgramCounter); end
    checks++; if (obs_fe !== 1'b0 || obs_fa !== 32'h0) begin errors++; $display("FAIL reset_fetch got en=%b addr=%h exp en=0 addr=0", obs_fe, obs_fa); end
  endtask

  task automatic test_fill();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (obs_fe !== 1'b1 || obs_fa !== 32'(4 * k)) begin errors++; $display("FAIL fill_req got en=%b addr=%h exp en=1 addr=%h", obs_fe, obs_fa, 32'(4 * k)); end
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_fe !== 1'b0) begin errors++; $display("FAIL fill_full_en got %b exp 0", obs_fe); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ got %0d exp 4", occupancy); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (lastValid !== 1'b1 || lastProgramCounter !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc got v=%b pc=%h exp v=1 pc=%h", lastValid, lastProgramCounter, 32'(4 * k)); end
      checks++; if (lastInstruction !== mem_word(32'(4 * k))) begin errors++; $display("FAIL stream_instr got %h exp %h", lastInstruction, mem_word(32'(4 * k))); end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL stream_occ got %0d exp 4", occupancy); end
    end
  endtask

  task automatic test_stall();
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (lastInstruction !== 32'hFFFF_FFFF || lastValid !== 1'b0 || currentPipeStall !== 1'b1) begin errors++; $display("FAIL stall_bubble got i=%h v=%b s=%b exp i=ffffffff v=0 s=1", lastInstruction, lastValid, currentPipeStall); end
    checks++; if (occupancy !== 3'd4 || lastProgramCounter !== 32'd28) begin errors++; $display("FAIL stall_hold got occ=%0d pc=%h exp occ=4 pc=0000001c", occupancy, lastProgramCounter); end
    checks++; if (obs_act !== 1'b0) begin errors++; $display("FAIL stall_active got %b exp 0", obs_act); end
  endtask

  task automatic test_redirect();
    bit seen = 0;
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    checks++; if (obs_fe !== 1'b1) begin errors++; $display("FAIL redir_same_req got %b exp 1", obs_fe); end
    checks++; if (occupancy !== 3'd0 || lastValid !== 1'b0) begin errors++; $display("FAIL redir_flush got occ=%0d v=%b exp occ=0 v=0", occupancy, lastValid); end
    for (int k = 0; k < 6 && !seen; k++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (k == 0) begin
        checks++; if (obs_fa !== 32'h100) begin errors++; $display("FAIL redir_addr got %h exp 00000100", obs_fa); end
      end
      seen = lastValid;
    end
    checks++; if (!seen || lastProgramCounter !== 32'h100) begin errors++; $display("FAIL redir_first got v=%b pc=%h exp v=1 pc=00000100", seen, lastProgramCounter); end
  endtask

  task automatic test_misaligned();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 1'b0);
    checks++; if (addressMisaligned !== 1'b1) begin errors++; $display("FAIL mis_set got %b exp 1", addressMisaligned); end
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (obs_fe !== 1'b0 || addressMisaligned !== 1'b1) begin errors++; $display("FAIL mis_halt got en=%b flag=%b exp en=0 flag=1", obs_fe, addressMisaligned); end
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    checks++; if (addressMisaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", addressMisaligned); end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_fe !== 1'b1 || obs_fa !== 32'h200) begin errors++; $display("FAIL mis_resume got en=%b addr=%h exp en=1 addr=00000200", obs_fe, obs_fa); end
  endtask

  task automatic test_busy_wrap();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (lastValid !== 1'b0 || currentPipeStall !== 1'b1 || occupancy !== 3'd0) begin errors++; $display("FAIL busy_bubble got v=%b s=%b occ=%0d exp v=0 s=1 occ=0", lastValid, currentPipeStall, occupancy); end
    end
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (lastValid !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("FAIL busy_nobypass got v=%b occ=%0d exp v=0 occ=1", lastValid, occupancy); end
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (lastValid !== 1'b1 || lastProgramCounter !== 32'hFFFF_FFF8) begin errors++; $display("FAIL busy_first got v=%b pc=%h exp v=1 pc=fffffff8", lastValid, lastProgramCounter); end
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_fa !== 32'h0 || lastProgramCounter !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap got addr=%h pc=%h exp addr=0 pc=fffffffc", obs_fa, lastProgramCounter); end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (occupancy !== 3'd0 || lastValid !== 1'b0 || lastInstruction !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset got occ=%0d v=%b i=%h exp occ=0 v=0 i=ffffffff", occupancy, lastValid, lastInstruction); end
    checks++; if (obs_fe !== 1'b0 || obs_fa !== 32'h0 || lastProgramCounter !== 32'h0) begin errors++; $display("FAIL midreset_fetch got en=%b addr=%h pc=%h exp 0/0/0", obs_fe, obs_fa, lastProgramCounter); end
  endtask

  task automatic test_random();
    logic        r, su, st, ps, rv, bz;
    logic [31:0] ra;
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(99) != 0);
      su = ($urandom_range(4) == 0);
      st = ($urandom_range(9) < 7);
      ps = ($urandom_range(3) == 0);
      rv = ($urandom_range(24) == 0);
      bz = ($urandom_range(9) < 3);
      ra = $urandom;
      if ($urandom_range(3) != 0) ra = ra & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
      apply(r, su, st, ps, rv, ra, bz);
      checks++; if ({obs_fe, obs_act, obs_fa} !== {exp_fe, exp_act, exp_fa}) begin errors++; $display("FAIL rnd_fetch cyc %0d got en=%b act=%b addr=%h exp en=%b act=%b addr=%h", n, obs_fe, obs_act, obs_fa, exp_fe, exp_act, exp_fa); end
      checks++; if ({lastInstruction, lastProgramCounter} !== {m_last_i, m_last_pc}) begin errors++; $display("FAIL rnd_last cyc %0d got i=%h pc=%h exp i=%h pc=%h", n, lastInstruction, lastProgramCounter, m_last_i, m_last_pc); end
      checks++; if ({lastValid, currentPipeStall, addressMisaligned, occupancy} !== {m_last_v, m_stall, m_mis, 3'(m_q.size())}) begin errors++; $display("FAIL rnd_status cyc %0d got v=%b s=%b m=%b occ=%0d exp v=%b s=%b m=%b occ=%0d", n, lastValid, currentPipeStall, addressMisaligned, occupancy, m_last_v, m_stall, m_mis, m_q.size()); end
    end
  endtask

  initial begin
    rst = 1'b0; pipeStartup = 1'b0; stepPipe = 1'b0; pipeStall = 1'b0;
    redirectValid = 1'b0; redirectAddress = 32'h0; busy_r = 1'b0;
    test_reset();
    test_fill();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_busy_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
